gpio_input_capture: RTL and testbench

//  Consumes the 32-bit bus assembled from the discrete badge input pins and makes it

---
 rtl/gpio_input_capture.sv | 152 +++++++++++++++
 tb/tb_gpio_input_capture.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_capture.sv
// gpio_input_capture
//   Makes the 32-bit pin bus from the pin-to-bus packer visible to the CPU over
//   Wishbone. Every bit is synchronised. Rising and falling edges are detected per bit
//   and latched into sticky pending bits. A level interrupt is raised while any bit is
//   pending.
//
//   Ports
//     clk, rst_n     system clock; synchronous active-low reset
//     gpio_in[31:0]  asynchronous pin bus (bit n = pin n)
//     wb_*           Wishbone slave
//                    word index wb_adr[1:0]:
//                      0 DATA (RO)
//                      1 RISE_EN (RW)
//                      2 FALL_EN (RW)
//                      3 PENDING (RW1C)
//     irq            high while any pending bit is set
//                    registered, so it lags pending by one cycle
//
//   Handshake: a strobe (wb_cyc & wb_stb) is acknowledged on the following edge,
//   provided wb_ack is not already high. That edge also commits any write and
//   registers read data. wb_ack is high for exactly one cycle. A strobe that is held
//   therefore completes one transfer every other cycle.
module gpio_input_capture #(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           gpio_in,
   input  logic [ADDR_WIDTH-1:0] wb_adr,
   input  logic [31:0]           wb_dat_i,
   input  logic [3:0]            wb_sel,
   input  logic                  wb_we,
   input  logic                  wb_cyc,
   input  logic                  wb_stb,
   output logic                  wb_ack,
   output logic [31:0]           wb_dat_o,
   output logic                  irq
);

   localparam int CW = $clog2(SYNC_STAGES + 2);
   localparam logic [CW-1:0] WARM_MAX = CW'(SYNC_STAGES + 1);

   localparam logic [1:0] A_DATA    = 2'd0;
   localparam logic [1:0] A_RISE_EN = 2'd1;
   localparam logic [1:0] A_FALL_EN = 2'd2;
   localparam logic [1:0] A_PENDING = 2'd3;

   logic [31:0]   sync_r [SYNC_STAGES];
   logic [31:0]   sync_q;
   logic [31:0]   prev;
   logic [31:0]   rise_en;
   logic [31:0]   fall_en;
   logic [31:0]   pending;
   logic [CW-1:0] warm_cnt;
   logic          warm_done;

   logic          xfer;
   logic          wr;
   logic [31:0]   lane_mask;
   logic [31:0]   clr;
   logic [31:0]   rise;
   logic [31:0]   fall;
   logic [31:0]   rd_data;
   logic [1:0]    idx;

   // Only the low two address bits are decoded; the rest are deliberately ignored.
   logic unused_adr;
   assign unused_adr = ^wb_adr;

   // Synchroniser chain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
      end else begin
         sync_r[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      end
   end

   assign sync_q = sync_r[SYNC_STAGES-1];

   // Warm-up counter. Edge detection stays masked until the chain and prev have
   // both filled with real pin values. Without this mask, a pin that is high out of
   // reset would look like a rising edge.
   always_ff @(posedge clk) begin
      if (!rst_n)                warm_cnt <= '0;
      else if (warm_cnt != WARM_MAX) warm_cnt <= warm_cnt + 1'b1;
   end

   assign warm_done = (warm_cnt == WARM_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) prev <= '0;
      else        prev <= sync_q;
   end

   assign rise = warm_done ? ( sync_q & ~prev) : '0;
   assign fall = warm_done ? (~sync_q &  prev) : '0;

   // Bus decode.
   assign idx       = wb_adr[1:0];
   assign xfer      = wb_cyc & wb_stb & ~wb_ack;
   assign wr        = xfer & wb_we;
   assign lane_mask = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
   assign clr       = (wr && idx == A_PENDING) ? (wb_dat_i & lane_mask) : '0;

   always_comb begin
      rd_data = '0;
      case (idx)
         A_DATA:    rd_data = sync_q;
         A_RISE_EN: rd_data = rise_en;
         A_FALL_EN: rd_data = fall_en;
         A_PENDING: rd_data = pending;
         default:   rd_data = '0;
      endcase
   end

   // Enable registers honour the byte lanes. Writes to DATA are acked but dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rise_en <= '0;
         fall_en <= '0;
      end else if (wr) begin
         if (idx == A_RISE_EN) rise_en <= (rise_en & ~lane_mask) | (wb_dat_i & lane_mask);
         if (idx == A_FALL_EN) fall_en <= (fall_en & ~lane_mask) | (wb_dat_i & lane_mask);
      end
   end

   // Sticky pending bits. The clear is applied before the set, so a new edge in the
   // same cycle as a W1C keeps its bit.
   always_ff @(posedge clk) begin
      if (!rst_n) pending <= '0;
      else        pending <= (pending & ~clr) | (rise & rise_en) | (fall & fall_en);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) irq <= 1'b0;
      else        irq <= |pending;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_ack   <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         wb_ack <= xfer;
         if (xfer && !wb_we) wb_dat_o <= rd_data;
      end
   end

endmodule

// File: tb/tb_gpio_input_capture.sv
// Directed bench for gpio_input_capture, using the default parameters
// (SYNC_STAGES=2, so pin-to-irq latency is 4 cycles).
// Every input is changed 1 time unit after a rising clock edge, and every output is
// sampled at that same point.
module tb_gpio_input_capture;

   logic        clk;
   logic        rst_n;
   logic [31:0] gpio_in;
   logic [3:0]  wb_adr;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel;
   logic        wb_we;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_ack;
   logic [31:0] wb_dat_o;
   logic        irq;

   int n_vec;
   int n_err;

   gpio_input_capture dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .gpio_in  (gpio_in),
      .wb_adr   (wb_adr),
      .wb_dat_i (wb_dat_i),
      .wb_sel   (wb_sel),
      .wb_we    (wb_we),
      .wb_cyc   (wb_cyc),
      .wb_stb   (wb_stb),
      .wb_ack   (wb_ack),
      .wb_dat_o (wb_dat_o),
      .irq      (irq)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
   endtask

   // driver tasks
   task automatic bus_idle();
      wb_cyc   = 1'b0;
      wb_stb   = 1'b0;
      wb_we    = 1'b0;
      wb_adr   = '0;
      wb_dat_i = '0;
      wb_sel   = '0;
   endtask

   task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      wb_cyc   = 1'b1;
      wb_stb   = 1'b1;
      wb_we    = 1'b1;
      wb_adr   = adr;
      wb_dat_i = dat;
      wb_sel   = sel;
      tick();
      bus_idle();
      tick();
   endtask

   task automatic wb_read(input logic [3:0] adr, output logic [31:0] dat);
      wb_cyc = 1'b1;
      wb_stb = 1'b1;
      wb_we  = 1'b0;
      wb_adr = adr;
      tick();
      dat = wb_dat_o;
      bus_idle();
      tick();
   endtask

   // tests
   task automatic test_reset();
      logic [31:0] d;
      gpio_in = '0;
      bus_idle();
      do_reset();
      n_vec++;
      if (wb_ack !== 1'b0 || wb_dat_o !== 32'h0 || irq !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: ack=%b dat_o=%h irq=%b, want 0/0/0", wb_ack, wb_dat_o, irq);
      end
      for (int a = 1; a < 4; a++) begin
         wb_read(a[3:0], d);
         n_vec++;
         if (d !== 32'h0) begin
            n_err++;
            $display("FAIL reset_reg%0d: got %h want 00000000", a, d);
         end
      end
   endtask

   task automatic test_warmup();
      logic [31:0] d;
      gpio_in = 32'hFFFF_FFFF;
      do_reset();
      wb_write(4'd1, 32'hFFFF_FFFF, 4'hF);
      tick(5);
      n_vec++;
      if (irq !== 1'b0) begin
         n_err++;
         $display("FAIL warmup_irq: got %b want 0", irq);
      end
      wb_read(4'd3, d);
      n_vec++;
      if (d !== 32'h0) begin
         n_err++;
         $display("FAIL warmup_pending: got %h want 00000000", d);
      end
      wb_read(4'd0, d);
      n_vec++;
      if (d !== 32'hFFFF_FFFF) begin
         n_err++;
         $display("FAIL warmup_data: got %h want ffffffff", d);
      end
   endtask

   task automatic test_rise_latency();
      logic [31:0] d;
      gpio_in = '0;
      do_reset();
      wb_write(4'd1, 32'h1, 4'hF);
      tick(4);
      gpio_in = 32'h1;
      tick(3);
      n_vec++;
      if (irq !== 1'b0) begin
         n_err++;
         $display("FAIL rise_irq_early: got %b want 0 after 3 cycles", irq);
      end
      tick();
      n_vec++;
      if (irq !== 1'b1) begin
         n_err++;
         $display("FAIL rise_irq_latency: got %b want 1 after 4 cycles", irq);
      end
      wb_read(4'd3, d);
      n_vec++;
      if (d !== 32'h1) begin
         n_err++;
         $display("FAIL rise_pending: got %h want 00000001", d);
      end
   endtask

   task automatic test_fall_w1c();
      logic [31:0] d;
      gpio_in = 32'h8000_0000;
      do_reset();
      wb_write(4'd2, 32'h8000_0000, 4'hF);
      tick(4);
      gpio_in = 32'h0;
      tick(4);
      n_vec++;
      if (irq !== 1'b1) begin
         n_err++;
         $display("FAIL fall_irq: got %b want 1", irq);
      end
      wb_read(4'd3, d);
      n_vec++;
      if (d !== 32'h8000_0000) begin
         n_err++;
         $display("FAIL fall_pending: got %h want 80000000", d);
      end
      // W1C, inline so the cycle after the ack can be observed
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
      wb_adr = 4'd3; wb_dat_i = 32'h8000_0000; wb_sel = 4'hF;
      tick();
      n_vec++;
      if (wb_ack !== 1'b1 || irq !== 1'b1) begin
         n_err++;
         $display("FAIL w1c_ack_edge: ack=%b irq=%b want 1/1", wb_ack, irq);
      end
      bus_idle();
      tick();
      n_vec++;
      if (irq !== 1'b0) begin
         n_err++;
         $display("FAIL w1c_irq_clear: got %b want 0", irq);
      end
   endtask

   task automatic test_set_beats_clear();
      logic [31:0] d;
      gpio_in = '0;
      do_reset();
      wb_write(4'd1, 32'h0000_0028, 4'hF);
      tick(3);
      gpio_in = 32'h20;
      tick(5);
      // bit 3 rises so that its set lands on the same edge as the W1C of bits 3 and 5
      gpio_in = 32'h28;
      tick(2);
      wb_write(4'd3, 32'h0000_0028, 4'hF);
      wb_read(4'd3, d);
      n_vec++;
      if (d !== 32'h0000_0008) begin
         n_err++;
         $display("FAIL set_beats_clear: got %h want 00000008", d);
      end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] d;
      gpio_in = '0;
      do_reset();
      wb_write(4'd1, 32'hAABB_CCDD, 4'b0101);
      wb_read(4'd1, d);
      n_vec++;
      if (d !== 32'h00BB_00DD) begin
         n_err++;
         $display("FAIL lanes_rise_en: got %h want 00bb00dd", d);
      end
      wb_write(4'd2, 32'hAABB_CCDD, 4'b1010);
      wb_read(4'hE, d);   // upper address bits ignored -> FALL_EN
      n_vec++;
      if (d !== 32'hAA00_CC00) begin
         n_err++;
         $display("FAIL lanes_fall_en: got %h want aa00cc00", d);
      end
      gpio_in = 32'h1234_5678;
      tick(3);
      wb_write(4'd0, 32'hFFFF_FFFF, 4'hF);
      wb_read(4'd0, d);
      n_vec++;
      if (d !== 32'h1234_5678) begin
         n_err++;
         $display("FAIL data_ro: got %h want 12345678", d);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      int pulses;
      gpio_in = '0;
      do_reset();
      pulses = 0;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 4'd1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (wb_ack === 1'b1) pulses++;
         n_vec++;
         if (wb_ack !== ((i % 2) == 0)) begin
            n_err++;
            $display("FAIL b2b_ack_cycle%0d: got %b want %b", i, wb_ack, (i % 2) == 0);
         end
      end
      bus_idle();
      tick();
      n_vec++;
      if (pulses != 3) begin
         n_err++;
         $display("FAIL b2b_pulses: got %0d want 3", pulses);
      end
      // build up state, then reset in the middle of a strobe
      wb_write(4'd1, 32'h0000_00F0, 4'hF);
      wb_write(4'd2, 32'h0000_0F00, 4'hF);
      gpio_in = 32'h10;
      tick(5);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 4'd1;
      wb_dat_i = 32'hFFFF_FFFF; wb_sel = 4'hF;
      rst_n = 1'b0;
      tick();
      n_vec++;
      if (wb_ack !== 1'b0 || irq !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_xfer: ack=%b irq=%b want 0/0", wb_ack, irq);
      end
      bus_idle();
      tick();
      rst_n = 1'b1;
      gpio_in = '0;
      for (int a = 1; a < 4; a++) begin
         wb_read(a[3:0], d);
         n_vec++;
         if (d !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid_reg%0d: got %h want 00000000", a, d);
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      gpio_in = '0;
      bus_idle();
      test_reset();
      test_warmup();
      test_rise_latency();
      test_fall_w1c();
      test_set_beats_clear();
      test_byte_lanes();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
